// File: rtl/prism_sp_unit_rx_mq_if.sv
// Bus bundle for the multi-queue SP RX command unit.
// It carries the issue, writeback, metadata-FIFO and DMA engine signals.
// The unit itself uses the slave modport; the environment uses the master modport.
interface prism_sp_unit_rx_mq_if #(
    parameter int NQUEUES      = 4,
    parameter int META_WIDTH   = 32,
    parameter int RESULT_WIDTH = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 16
);
    logic                          issue_new_request;
    logic                          issue_ready;
    logic [4:0]                    issue_cmd;
    logic [31:0]                   issue_rs1;
    logic [31:0]                   issue_rs2;
    logic                          wb_done;
    logic [RESULT_WIDTH-1:0]       result;
    logic [NQUEUES-1:0]            meta_rd_en;
    logic [NQUEUES*META_WIDTH-1:0] meta_rd_data;
    logic [NQUEUES-1:0]            meta_empty;
    logic                          dma_start;
    logic [ADDR_WIDTH-1:0]         dma_addr;
    logic [LEN_WIDTH-1:0]          dma_len;
    logic                          dma_busy;

    modport slave (
        input  issue_new_request, issue_cmd, issue_rs1, issue_rs2,
        input  meta_rd_data, meta_empty, dma_busy,
        output issue_ready, wb_done, result, meta_rd_en,
        output dma_start, dma_addr, dma_len
    );

    modport master (
        output issue_new_request, issue_cmd, issue_rs1, issue_rs2,
        output meta_rd_data, meta_empty, dma_busy,
        input  issue_ready, wb_done, result, meta_rd_en,
        input  dma_start, dma_addr, dma_len
    );
endinterface

// File: rtl/prism_sp_unit_rx_mq.sv
// Multi-queue SP RX command unit.
// It executes one-hot RX commands against NQUEUES FWFT metadata FIFOs.
// DMA start descriptors are buffered in a small start queue.
// A three-state launcher drains that queue into the single DMA write engine.
module prism_sp_unit_rx_mq #(
    parameter int NQUEUES      = 4,
    parameter int META_WIDTH   = 32,
    parameter int RESULT_WIDTH = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 16,
    parameter int DMA_QDEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    prism_sp_unit_rx_mq_if.slave   bus
);
    localparam int QSEL_W = (NQUEUES > 1) ? $clog2(NQUEUES) : 1;
    localparam int PTR_W  = $clog2(DMA_QDEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    inflight_q;
    logic                    wb_done_q;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic [NQUEUES-1:0]      meta_rd_en_q, meta_rd_en_d;
    logic                    dma_start_q;
    logic [ADDR_WIDTH-1:0]   dma_addr_q;
    logic [LEN_WIDTH-1:0]    dma_len_q;
    logic err_pop_empty_q, err_qsel_q, err_zero_len_q, err_illegal_q;
    logic err_pop_empty_d, err_qsel_d, err_zero_len_d, err_illegal_d;

    logic [ADDR_WIDTH-1:0]   addr_mem_q [DMA_QDEPTH];
    logic [LEN_WIDTH-1:0]    len_mem_q  [DMA_QDEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    pop_s, push_s, full_s, ready_s, accept_s;
    logic                    guard_s, qsel_ok_s, head_empty_s;
    logic [QSEL_W-1:0]       qsel_s;
    logic [META_WIDTH-1:0]   head_data_s;

    assign guard_s = (state_q == ST_GUARD);
    // A launcher pop in this cycle frees a slot, so a full queue can still accept.
    assign full_s   = (count_q == CNT_W'(DMA_QDEPTH)) && !pop_s;
    assign ready_s  = rst_n && !inflight_q && !(bus.issue_cmd[2] && full_s);
    assign accept_s = bus.issue_new_request && ready_s;

    // The whole rs1 value is range-checked, so out-of-range selects never alias a valid queue.
    assign qsel_ok_s = (bus.issue_rs1 < 32'(NQUEUES));
    assign qsel_s    = bus.issue_rs1[QSEL_W-1:0];

    // Select the head word and empty flag of the addressed metadata queue.
    always_comb begin
        head_data_s  = '0;
        head_empty_s = 1'b1;
        for (int q = 0; q < NQUEUES; q++) begin
            if (qsel_s == QSEL_W'(q)) begin
                head_data_s  = bus.meta_rd_data[q*META_WIDTH +: META_WIDTH];
                head_empty_s = bus.meta_empty[q];
            end else begin
                head_data_s  = head_data_s;
                head_empty_s = head_empty_s;
            end
        end
    end

    // Launcher next-state logic; in IDLE it pops the start queue when the engine is free.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count_q != CNT_W'(0)) && !bus.dma_busy) begin
                    pop_s   = 1'b1;
                    state_d = ST_GUARD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!bus.dma_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command decode: result, pop strobe, queue push and sticky error updates for an accepted command.
    always_comb begin
        result_d        = '0;
        meta_rd_en_d    = '0;
        push_s          = 1'b0;
        err_pop_empty_d = err_pop_empty_q;
        err_qsel_d      = err_qsel_q;
        err_zero_len_d  = err_zero_len_q;
        err_illegal_d   = err_illegal_q;
        if (accept_s) begin
            case (bus.issue_cmd)
                5'b00001: begin
                    if (!qsel_ok_s) begin
                        err_qsel_d = 1'b1;
                    end else if (head_empty_s) begin
                        err_pop_empty_d = 1'b1;
                    end else begin
                        result_d     = RESULT_WIDTH'(head_data_s);
                        meta_rd_en_d = NQUEUES'(1) << qsel_s;
                    end
                end
                5'b00010: result_d[NQUEUES-1:0] = bus.meta_empty;
                5'b00100: begin
                    if (bus.issue_rs2[LEN_WIDTH-1:0] == LEN_WIDTH'(0)) begin
                        err_zero_len_d = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end
                5'b01000: begin
                    result_d[0]          = bus.dma_busy | guard_s;
                    result_d[1]          = (count_q != CNT_W'(0));
                    result_d[8 +: CNT_W] = count_q;
                    result_d[16]         = err_pop_empty_q;
                    result_d[17]         = err_qsel_q;
                    result_d[18]         = err_zero_len_q;
                    result_d[19]         = err_illegal_q;
                end
                5'b10000: begin
                    err_pop_empty_d = 1'b0;
                    err_qsel_d      = 1'b0;
                    err_zero_len_d  = 1'b0;
                    err_illegal_d   = 1'b0;
                end
                default: err_illegal_d = 1'b1;
            endcase
        end else begin
            result_d = '0;
        end
    end

    // Writeback, pop strobe, inflight throttle and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            wb_done_q       <= 1'b0;
            result_q        <= '0;
            meta_rd_en_q    <= '0;
            err_pop_empty_q <= 1'b0;
            err_qsel_q      <= 1'b0;
            err_zero_len_q  <= 1'b0;
            err_illegal_q   <= 1'b0;
        end else begin
            inflight_q      <= accept_s;
            wb_done_q       <= accept_s;
            meta_rd_en_q    <= meta_rd_en_d;
            err_pop_empty_q <= err_pop_empty_d;
            err_qsel_q      <= err_qsel_d;
            err_zero_len_q  <= err_zero_len_d;
            err_illegal_q   <= err_illegal_d;
            if (accept_s) begin
                result_q <= result_d;
            end else begin
                result_q <= result_q;
            end
        end
    end

    // Start-queue storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_q[wr_ptr_q] <= bus.issue_rs1[ADDR_WIDTH-1:0];
            len_mem_q[wr_ptr_q]  <= bus.issue_rs2[LEN_WIDTH-1:0];
        end
    end

    // Start-queue pointers and occupancy; push and pop may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Launcher state register and registered DMA start/address/length outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dma_start_q <= 1'b0;
            dma_addr_q  <= '0;
            dma_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            dma_start_q <= pop_s;
            if (pop_s) begin
                dma_addr_q <= addr_mem_q[rd_ptr_q];
                dma_len_q  <= len_mem_q[rd_ptr_q];
            end
        end
    end

    assign bus.issue_ready = ready_s;
    assign bus.wb_done     = wb_done_q;
    assign bus.result      = result_q;
    assign bus.meta_rd_en  = meta_rd_en_q;
    assign bus.dma_start   = dma_start_q;
    assign bus.dma_addr    = dma_addr_q;
    assign bus.dma_len     = dma_len_q;
endmodule

// File: tb/tb_prism_sp_unit_rx_mq.sv
// Directed bench for prism_sp_unit_rx_mq: a vector table of single commands,
// followed by hand-written DMA queue-fill, launch-latency and reset sequences.
module tb_prism_sp_unit_rx_mq;
    localparam logic [4:0] C_POP    = 5'b00001;
    localparam logic [4:0] C_EMPTY  = 5'b00010;
    localparam logic [4:0] C_START  = 5'b00100;
    localparam logic [4:0] C_STATUS = 5'b01000;
    localparam logic [4:0] C_CLR    = 5'b10000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    prism_sp_unit_rx_mq_if #(.NQUEUES(4), .META_WIDTH(32), .RESULT_WIDTH(32),
                             .ADDR_WIDTH(32), .LEN_WIDTH(16)) bus ();

    prism_sp_unit_rx_mq #(.NQUEUES(4), .META_WIDTH(32), .RESULT_WIDTH(32),
                          .ADDR_WIDTH(32), .LEN_WIDTH(16), .DMA_QDEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Metadata FIFO model (FWFT): q0={11111111}, q1 empty, q2={CAFE0001,CAFE0002}, q3={33333333}
    logic [31:0] mfifo [4][4];
    int mhead [4] = '{0, 0, 0, 0};
    int mcnt  [4] = '{1, 0, 2, 1};
    int rdcnt [4] = '{0, 0, 0, 0};
    initial begin
        for (int q = 0; q < 4; q++) for (int k = 0; k < 4; k++) mfifo[q][k] = 32'h0;
        mfifo[0][0] = 32'h11111111;
        mfifo[2][0] = 32'hCAFE0001;
        mfifo[2][1] = 32'hCAFE0002;
        mfifo[3][0] = 32'h33333333;
    end
    for (genvar g = 0; g < 4; g++) begin : g_meta
        assign bus.meta_rd_data[g*32 +: 32] = mfifo[g][mhead[g]];
        assign bus.meta_empty[g]            = (mcnt[g] == 0);
    end
    always @(posedge clk) begin
        for (int q = 0; q < 4; q++) begin
            if (bus.meta_rd_en[q]) begin
                rdcnt[q] <= rdcnt[q] + 1;
                if (mcnt[q] > 0) begin
                    mhead[q] <= mhead[q] + 1;
                    mcnt[q]  <= mcnt[q] - 1;
                end
            end
        end
    end

    // DMA engine model: busy for 3 cycles after each start, or while hold_busy is set
    logic hold_busy = 1'b0;
    int   eng_cnt   = 0;
    int   cyc       = 0;
    logic [47:0] launch_q[$];
    int          launch_cyc[$];
    assign bus.dma_busy = hold_busy | (eng_cnt != 0);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.dma_start) begin
            eng_cnt <= 3;
            launch_q.push_back({bus.dma_addr, bus.dma_len});
            launch_cyc.push_back(cyc);
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Offer one command, wait (bounded) for acceptance, sample outputs in cycle T+1
    task automatic do_cmd(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] rden, output logic wbd);
        bit got = 0;
        bus.issue_cmd = c;
        bus.issue_rs1 = a;
        bus.issue_rs2 = b;
        bus.issue_new_request = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.issue_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: cmd 0x%0h never accepted", c);
            bus.issue_new_request = 1'b0;
            res = 32'h0; rden = 4'h0; wbd = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.issue_new_request = 1'b0;
            res  = bus.result;
            rden = bus.meta_rd_en;
            wbd  = bus.wb_done;
        end
    endtask

    typedef struct {
        logic [4:0]  cmd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp_res;
        logic [3:0]  exp_rden;
    } vec_t;
    vec_t vecs [20];

    logic [31:0] r;
    logic [3:0]  rd;
    logic        wb;
    int          nlaunch;
    logic [47:0] exp_launch [5];

    initial begin
        bus.issue_new_request = 1'b0;
        bus.issue_cmd = 5'b0;
        bus.issue_rs1 = 32'h0;
        bus.issue_rs2 = 32'h0;

        vecs[0]  = '{C_EMPTY,  32'h0, 32'h0, 32'h00000002, 4'b0000};
        vecs[1]  = '{C_POP,    32'h2, 32'h0, 32'hCAFE0001, 4'b0100};
        vecs[2]  = '{C_POP,    32'h2, 32'h0, 32'hCAFE0002, 4'b0100};
        vecs[3]  = '{C_EMPTY,  32'h3, 32'h0, 32'h00000006, 4'b0000};
        vecs[4]  = '{C_POP,    32'h1, 32'h0, 32'h00000000, 4'b0000};
        vecs[5]  = '{C_STATUS, 32'h0, 32'h0, 32'h00010000, 4'b0000};
        vecs[6]  = '{C_POP,    32'h7, 32'h0, 32'h00000000, 4'b0000};
        vecs[7]  = '{C_STATUS, 32'h0, 32'h0, 32'h00030000, 4'b0000};
        vecs[8]  = '{C_CLR,    32'h0, 32'h0, 32'h00000000, 4'b0000};
        vecs[9]  = '{C_STATUS, 32'h0, 32'h0, 32'h00000000, 4'b0000};
        vecs[10] = '{5'b00101, 32'h0, 32'h5, 32'h00000000, 4'b0000};
        vecs[11] = '{C_STATUS, 32'h0, 32'h0, 32'h00080000, 4'b0000};
        vecs[12] = '{C_START,  32'h1000, 32'h0, 32'h00000000, 4'b0000};
        vecs[13] = '{C_STATUS, 32'h0, 32'h0, 32'h000C0000, 4'b0000};
        vecs[14] = '{C_POP,    32'h0, 32'h0, 32'h11111111, 4'b0001};
        vecs[15] = '{C_POP,    32'h3, 32'h0, 32'h33333333, 4'b1000};
        vecs[16] = '{C_CLR,    32'h0, 32'h0, 32'h00000000, 4'b0000};
        vecs[17] = '{5'b00000, 32'h0, 32'h0, 32'h00000000, 4'b0000};
        vecs[18] = '{C_STATUS, 32'h0, 32'h0, 32'h00080000, 4'b0000};
        vecs[19] = '{C_CLR,    32'h0, 32'h0, 32'h00000000, 4'b0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_done", 48'(bus.wb_done), 48'h0);
        chk("rst_result", 48'(bus.result), 48'h0);
        chk("rst_meta_rd_en", 48'(bus.meta_rd_en), 48'h0);
        chk("rst_dma_start", 48'(bus.dma_start), 48'h0);
        chk("rst_dma_addr_len", {bus.dma_addr, bus.dma_len}, 48'h0);
        chk("rst_issue_ready", 48'(bus.issue_ready), 48'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < 20; i++) begin
            do_cmd(vecs[i].cmd, vecs[i].rs1, vecs[i].rs2, r, rd, wb);
            chk($sformatf("vec%0d_wb_done", i), 48'(wb), 48'h1);
            chk($sformatf("vec%0d_result", i), 48'(r), 48'(vecs[i].exp_res));
            chk($sformatf("vec%0d_rd_en", i), 48'(rd), 48'(vecs[i].exp_rden));
        end
        @(posedge clk);
        #1;
        chk("wb_done_single_pulse", 48'(bus.wb_done), 48'h0);
        chk("no_launch_zero_len", 48'(launch_q.size()), 48'h0);

        // Queue fill with engine held busy
        for (int i = 0; i < 5; i++) exp_launch[i] = {32'h00010000 * (i + 1), 16'h0010 * 16'(i + 1)};
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_cmd(C_START, exp_launch[i][47:16], 32'(exp_launch[i][15:0]), r, rd, wb);
            if (i == 2) begin
                do_cmd(C_STATUS, 32'h0, 32'h0, r, rd, wb);
                chk("status_3_queued", 48'(r), 48'h00000303);
            end
        end
        bus.issue_cmd = C_START;
        bus.issue_rs1 = exp_launch[4][47:16];
        bus.issue_rs2 = 32'(exp_launch[4][15:0]);
        bus.issue_new_request = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("full_stall%0d", k), 48'(bus.issue_ready), 48'h0);
        end
        @(posedge clk);
        #1;
        hold_busy = 1'b0;
        do_cmd(C_START, exp_launch[4][47:16], 32'(exp_launch[4][15:0]), r, rd, wb);
        chk("fifth_accept_wb", 48'(wb), 48'h1);
        chk("first_launch_with_fifth", {47'h0, bus.dma_start}, 48'h1);
        chk("first_launch_addr_len", {bus.dma_addr, bus.dma_len}, exp_launch[0]);
        for (int n = 0; n < 200 && launch_q.size() < 5; n++) @(posedge clk);
        #1;
        chk("launch_count", 48'(launch_q.size()), 48'h5);
        for (int i = 0; i < 5 && i < launch_q.size(); i++)
            chk($sformatf("launch%0d_order", i), launch_q[i], exp_launch[i]);
        for (int i = 1; i < 5 && i < launch_cyc.size(); i++)
            chk($sformatf("launch%0d_spacing_ge3", i),
                48'(launch_cyc[i] - launch_cyc[i-1] >= 3), 48'h1);

        // Earliest launch: idle engine, empty queue -> dma_start at T+2
        repeat (10) @(posedge clk);
        #1;
        do_cmd(C_START, 32'hABCD0000, 32'h40, r, rd, wb);
        chk("launch_not_at_t1", 48'(bus.dma_start), 48'h0);
        @(posedge clk);
        #1;
        chk("launch_at_t2", {bus.dma_start, bus.dma_addr, bus.dma_len}, {1'b1, 32'hABCD0000, 16'h0040});

        // Reset with FSM in WAIT and two starts queued
        repeat (10) @(posedge clk);
        #1;
        do_cmd(C_START, 32'h00005000, 32'h8, r, rd, wb);
        @(posedge clk);
        #1;
        hold_busy = 1'b1;
        do_cmd(C_START, 32'h00006000, 32'h9, r, rd, wb);
        do_cmd(C_START, 32'h00007000, 32'hA, r, rd, wb);
        do_cmd(C_STATUS, 32'h0, 32'h0, r, rd, wb);
        chk("status_before_reset", 48'(r), 48'h00000203);
        nlaunch = launch_q.size();
        chk("launch_count_before_reset", 48'(nlaunch), 48'h7);
        do_cmd(C_EMPTY, 32'h0, 32'h0, r, rd, wb);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_result", {15'h0, bus.wb_done, bus.result}, 48'h0);
        chk("mid_rst_dma", {bus.dma_start, bus.dma_addr[14:0], bus.dma_len, bus.meta_rd_en, 12'h0}, 48'h0);
        chk("mid_rst_issue_ready", 48'(bus.issue_ready), 48'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold_busy = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_launch_after_reset", 48'(launch_q.size()), 48'(nlaunch));
        do_cmd(C_STATUS, 32'h0, 32'h0, r, rd, wb);
        chk("status_after_reset", 48'(r), 48'h0);

        // Pop strobes per queue over the whole run
        for (int q = 0; q < 4; q++)
            chk($sformatf("rd_en_pulses_q%0d", q), 48'(rdcnt[q]), 48'(q == 0 ? 1 : q == 1 ? 0 : q == 2 ? 2 : 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
